instr_queue: RTL and testbench

INSTR_QUEUE -- requirements
Module: instr_queue

---
 rtl/instr_queue.sv | 81 ++++++++
 tb/tb_instr_queue.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/instr_queue.sv
// instr_queue: circular FIFO of LC-3b instruction words with combinational head decode
module instr_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [15:0]                in_word,
  output logic                       in_ready,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       head_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [3:0]                 opcode,
  output logic [2:0]                 dest,
  output logic [2:0]                 src1,
  output logic [2:0]                 src2,
  output logic [5:0]                 offset6,
  output logic [7:0]                 trapvect8,
  output logic [8:0]                 offset9,
  output logic [10:0]                offset11,
  output logic [4:0]                 imm5,
  output logic [3:0]                 imm4,
  output logic                       imm5_bit,
  output logic                       imm4_bit,
  output logic                       instr_bit11,
  output logic [15:0]                adj6,
  output logic [15:0]                adj9,
  output logic [15:0]                adj11
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic          push, take;
  logic [15:0]   head;
  assign in_ready   = count != CW'(DEPTH);
  assign head_valid = count != '0;
  assign push       = in_valid && in_ready && !flush;
  assign take       = pop && head_valid && !flush;
  // pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      rd    <= take ? rd + AW'(1) : rd;
      wr    <= push ? wr + AW'(1) : wr;
      count <= count + CW'(push) - CW'(take);
    end
  end
  // entry storage is not reset; stale contents are hidden while count is zero
  always_ff @(posedge clk) begin
    if (push) mem[wr] <= in_word;
  end
  // head decode fields, forced to zero when the queue is empty
  always_comb begin
    head        = head_valid ? mem[rd] : 16'h0;
    opcode      = head[15:12];
    dest        = head[11:9];
    src1        = head[8:6];
    src2        = head[2:0];
    offset6     = head[5:0];
    trapvect8   = head[7:0];
    offset9     = head[8:0];
    offset11    = head[10:0];
    imm5        = head[4:0];
    imm4        = head[3:0];
    imm5_bit    = head[5];
    imm4_bit    = head[4];
    instr_bit11 = head[11];
    adj6        = {{9{head[5]}}, head[5:0], 1'b0};
    adj9        = {{6{head[8]}}, head[8:0], 1'b0};
    adj11       = {{4{head[10]}}, head[10:0], 1'b0};
  end
endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed self-checking bench for instr_queue at DEPTH 4
module tb_instr_queue;
  logic        clk = 0;
  logic        reset, in_valid, pop, flush, in_ready, head_valid;
  logic [15:0] in_word;
  logic [2:0]  count;
  logic [3:0]  opcode, imm4;
  logic [2:0]  dest, src1, src2;
  logic [5:0]  offset6;
  logic [7:0]  trapvect8;
  logic [8:0]  offset9;
  logic [10:0] offset11;
  logic [4:0]  imm5;
  logic        imm5_bit, imm4_bit, instr_bit11;
  logic [15:0] adj6, adj9, adj11;
  int total = 0, bad = 0;
  logic [15:0] w [12];

  instr_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_word(in_word),
    .in_ready(in_ready), .pop(pop), .flush(flush), .head_valid(head_valid),
    .count(count), .opcode(opcode), .dest(dest), .src1(src1), .src2(src2),
    .offset6(offset6), .trapvect8(trapvect8), .offset9(offset9),
    .offset11(offset11), .imm5(imm5), .imm4(imm4), .imm5_bit(imm5_bit),
    .imm4_bit(imm4_bit), .instr_bit11(instr_bit11), .adj6(adj6),
    .adj9(adj9), .adj11(adj11)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] hw();
    return {opcode, instr_bit11, offset11};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; in_valid = 0; pop = 0; flush = 0; in_word = 16'h0;
    step(); step();
    chk("rst_count", 16'(count), 16'd0);
    chk("rst_hv", 16'(head_valid), 16'd0);
    chk("rst_rdy", 16'(in_ready), 16'd1);
    chk("rst_adj9", adj9, 16'h0);
    reset = 0;
    // decode of 0x1234
    in_valid = 1; in_word = 16'h1234; step(); in_valid = 0;
    chk("dec_hv", 16'(head_valid), 16'd1);
    chk("dec_op", 16'(opcode), 16'd1);
    chk("dec_dest", 16'(dest), 16'd1);
    chk("dec_src1", 16'(src1), 16'd0);
    chk("dec_i5b", 16'(imm5_bit), 16'd1);
    chk("dec_imm5", 16'(imm5), 16'h14);
    chk("dec_src2", 16'(src2), 16'd4);
    chk("dec_tv8", 16'(trapvect8), 16'h34);
    chk("dec_i4", 16'({imm4_bit, imm4}), 16'h14);
    chk("dec_count", 16'(count), 16'd1);
    pop = 1; step(); pop = 0;
    chk("pop_count", 16'(count), 16'd0);
    chk("pop_hv", 16'(head_valid), 16'd0);
    chk("pop_op", 16'(opcode), 16'd0);
    // sign extension
    in_valid = 1; in_word = 16'h01FF; step();
    chk("sx_adj9", adj9, 16'hFFFE);
    pop = 1; in_word = 16'h4FFF; step();
    chk("sx_adj11", adj11, 16'hFFFE);
    chk("sx_b11", 16'(instr_bit11), 16'd1);
    chk("sx_cnt", 16'(count), 16'd1);
    in_word = 16'h0020; step(); in_valid = 0;
    chk("sx_adj6", adj6, 16'hFFC0);
    chk("sx_adj9p", adj9, 16'h0040);
    step(); pop = 0;
    chk("sx_empty", 16'(count), 16'd0);
    // full
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      in_word = 16'h1000 + 16'(i) * 16'h1111;
      step();
      if (i == 3) begin
        chk("full_cnt4", 16'(count), 16'd4);
        chk("full_rdy", 16'(in_ready), 16'd0);
      end
    end
    in_valid = 0;
    chk("full_cnt5", 16'(count), 16'd4);
    pop = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("full_word%0d", i), hw(), 16'h1000 + 16'(i) * 16'h1111);
      step();
    end
    pop = 0;
    chk("full_hv", 16'(head_valid), 16'd0);
    // wrap / throughput
    for (int i = 0; i < 12; i++) w[i] = 16'hC000 + 16'(i) * 16'h0123;
    in_valid = 1;
    in_word = w[0]; step();
    in_word = w[1]; step();
    pop = 1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("wrap_head%0d", k), hw(), w[k]);
      in_word = w[k+2];
      step();
    end
    in_valid = 0;
    chk("wrap_cnt", 16'(count), 16'd2);
    chk("wrap_h10", hw(), w[10]); step();
    chk("wrap_h11", hw(), w[11]); step();
    pop = 0;
    chk("wrap_empty", 16'(count), 16'd0);
    // flush and empty pop
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin in_word = 16'h2000 + 16'(i); step(); end
    chk("fl_cnt3", 16'(count), 16'd3);
    flush = 1; pop = 1; in_word = 16'h7777; step();
    flush = 0; in_valid = 0;
    chk("fl_cnt0", 16'(count), 16'd0);
    chk("fl_hv", 16'(head_valid), 16'd0);
    step(); pop = 0;
    chk("ep_cnt", 16'(count), 16'd0);
    chk("ep_rdy", 16'(in_ready), 16'd1);
    // reset mid-operation
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin in_word = 16'h3000 + 16'(i); step(); end
    chk("rm_cnt3", 16'(count), 16'd3);
    #2 reset = 1;
    #1;
    chk("rm_cnt", 16'(count), 16'd0);
    chk("rm_hv", 16'(head_valid), 16'd0);
    chk("rm_op", 16'(opcode), 16'd0);
    chk("rm_adj11", adj11, 16'h0);
    pop = 1; flush = 0; in_word = 16'h5555;
    step(); step();
    chk("rm_hold", 16'(count), 16'd0);
    reset = 0; pop = 0; in_word = 16'hBEEF;
    step(); in_valid = 0;
    chk("rm_cnt1", 16'(count), 16'd1);
    chk("rm_head", hw(), 16'hBEEF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
